// File: rtl/ahb_master_cdl.sv
// Single-outstanding AHB-Lite initiator: one command handshake becomes one
// address phase plus one data phase, then one response handshake.
module ahb_master_cdl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        hsel,
  output logic [3:0]  haddr,
  output logic [1:0]  htrans,
  output logic [1:0]  hsize,
  output logic        hwrite,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hresp,
  input  logic        hready,
  output logic [15:0] txn_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic        lat_write;
  logic [3:0]  lat_addr;
  logic [1:0]  lat_size;
  logic [31:0] lat_wdata;

  logic        accept;
  logic        done_ok;
  logic        fail_resp;
  logic        fail_timeout;
  logic        wait_inc;
  logic        rsp_done;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    done_ok      = 1'b0;
    fail_resp    = 1'b0;
    fail_timeout = 1'b0;
    wait_inc     = 1'b0;
    rsp_done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (hresp) begin
          fail_resp = 1'b1;
          state_nxt = S_RESP;
        end else begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        // hresp outranks both normal completion and a coincident timeout.
        if (hresp) begin
          fail_resp = 1'b1;
          state_nxt = S_RESP;
        end else if (hready) begin
          done_ok   = 1'b1;
          state_nxt = S_RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          fail_timeout = 1'b1;
          state_nxt    = S_RESP;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the latched command is not reset; every bus output that shows it is
  // gated by state, so its contents are never visible while idle.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write <= cmd_write;
      lat_addr  <= cmd_addr;
      lat_size  <= cmd_size;
      lat_wdata <= cmd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      txn_count   <= '0;
      err_count   <= '0;
    end else begin
      if (accept) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (done_ok) begin
        rsp_rdata   <= lat_write ? 32'd0 : hrdata;
        rsp_error   <= 1'b0;
        rsp_timeout <= 1'b0;
      end else if (fail_resp || fail_timeout) begin
        rsp_rdata   <= '0;
        rsp_error   <= 1'b1;
        rsp_timeout <= fail_timeout;
      end else if (rsp_done) begin
        rsp_rdata   <= '0;
        rsp_error   <= 1'b0;
        rsp_timeout <= 1'b0;
      end

      if (rsp_done) begin
        txn_count <= txn_count + 16'd1;
        if (rsp_error && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

  logic bus_active;

  assign bus_active = (state == S_ADDR) || (state == S_DATA);
  assign cmd_ready  = (state == S_IDLE);
  assign rsp_valid  = (state == S_RESP);
  assign hsel       = bus_active;
  assign htrans     = (state == S_ADDR) ? 2'b10 : 2'b00;
  assign haddr      = bus_active ? lat_addr  : 4'd0;
  assign hsize      = bus_active ? lat_size  : 2'd0;
  assign hwrite     = bus_active ? lat_write : 1'b0;
  assign hwdata     = ((state == S_DATA) && lat_write) ? lat_wdata : 32'd0;

endmodule

// File: tb/tb_ahb_master_cdl.sv
// Directed bench for ahb_master_cdl: stimulus pushes expected responses into a
// queue, a monitor pops and compares on every response handshake.
module tb_ahb_master_cdl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_addr = 4'd0;
  logic [1:0]  cmd_size = 2'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hresp = 1'b0;
  logic        hready = 1'b1;
  logic [15:0] txn_count;
  logic [7:0]  err_count;

  logic        garbage = 1'b0;
  logic [31:0] mem [16];

  ahb_master_cdl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp),
    .hready(hready), .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Minimal slave: stores completed data-phase writes, returns junk on demand.
  initial for (int i = 0; i < 16; i++) mem[i] = 32'd0;
  always @(posedge clk)
    if (hsel && htrans == 2'b00 && hwrite && hready && !hresp) mem[haddr] <= hwdata;
  assign hrdata = garbage ? 32'hBAD0BAD0 : mem[haddr];

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        timeout;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic rsp_t mk(input logic [31:0] d, input logic e, input logic t);
    rsp_t r;
    r.rdata   = d;
    r.error   = e;
    r.timeout = t;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge, i.e. during the address phase.
  task automatic send(input logic w, input logic [3:0] a, input logic [1:0] s,
                      input logic [31:0] d, input logic push, input rsp_t exp);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
    if (push) exp_q.push_back(exp);
    while (!cmd_ready && n < 50) begin
      tick;
      n++;
    end
    check("cmd_accept_in_time", 32'(n < 50), 32'd1);
    tick;
    cmd_valid = 1'b0;
  endtask

  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_error", 32'(rsp_error), 32'(e.error));
          check("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (3) tick;
    rst = 1'b0;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_rsp", {rsp_valid, rsp_error, rsp_timeout}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_bus", {hsel, htrans, haddr, hsize, hwrite}, 32'd0);
    check("reset_hwdata", hwdata, 32'd0);
    check("reset_counters", {txn_count, err_count}, 32'd0);

    // Zero-wait write then read back.
    rsp_ready = 1'b1;
    send(1'b1, 4'd0, 2'd2, 32'hDEADBEEF, 1'b1, mk(32'd0, 1'b0, 1'b0));
    check("wr_addr_phase", {hsel, htrans, haddr, hsize, hwrite},
          {1'b1, 2'b10, 4'd0, 2'd2, 1'b1});
    check("wr_addr_cmd_ready", 32'(cmd_ready), 32'd0);
    tick;
    check("wr_data_phase", {hsel, htrans, cmd_ready}, {1'b1, 2'b00, 1'b0});
    check("wr_hwdata", hwdata, 32'hDEADBEEF);
    tick;
    check("wr_rsp_cycle3", {rsp_valid, hsel}, 32'b10);
    tick;
    check("wr_next_ready", 32'(cmd_ready), 32'd1);
    check("wr_txn_count", 32'(txn_count), 32'd1);

    send(1'b0, 4'd0, 2'd2, 32'h0, 1'b1, mk(32'hDEADBEEF, 1'b0, 1'b0));
    tick;
    check("rd_hwdata_zero", {hwrite, hwdata}, 33'd0);
    tick;
    tick;
    check("rd_txn_count", 32'(txn_count), 32'd2);

    // Address-phase error: DATA skipped.
    send(1'b1, 4'd5, 2'd2, 32'h11112222, 1'b1, mk(32'd0, 1'b1, 1'b0));
    hresp = 1'b1;
    tick;
    hresp = 1'b0;
    check("aerr_skips_data", {hsel, rsp_valid}, 32'b01);
    tick;
    check("aerr_err_count", 32'(err_count), 32'd1);
    check("aerr_txn_count", 32'(txn_count), 32'd3);

    // Three wait states: response three cycles later than zero-wait.
    send(1'b0, 4'd0, 2'd2, 32'h0, 1'b1, mk(32'hDEADBEEF, 1'b0, 1'b0));
    hready = 1'b0;
    repeat (4) tick;
    check("wait_still_data", {hsel, rsp_valid}, 32'b10);
    hready = 1'b1;
    tick;
    check("wait_rsp_valid", 32'(rsp_valid), 32'd1);
    tick;
    check("wait_txn_count", 32'(txn_count), 32'd4);

    // Timeout after 16 DATA cycles with hready low.
    garbage = 1'b1;
    send(1'b0, 4'd3, 2'd1, 32'h0, 1'b1, mk(32'd0, 1'b1, 1'b1));
    hready = 1'b0;
    tick;
    repeat (15) tick;
    check("tmo_still_data", {hsel, rsp_valid}, 32'b10);
    tick;
    check("tmo_bus_idle", {hsel, htrans, haddr, hsize, hwrite, rsp_valid},
          {1'b0, 2'b00, 4'd0, 2'd0, 1'b0, 1'b1});
    hready  = 1'b1;
    garbage = 1'b0;
    tick;
    check("tmo_err_count", 32'(err_count), 32'd2);

    // Response backpressure with a competing command held on the input.
    rsp_ready = 1'b0;
    send(1'b0, 4'd0, 2'd2, 32'h0, 1'b1, mk(32'hDEADBEEF, 1'b0, 1'b0));
    tick;
    tick;
    garbage   = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'd9;
    cmd_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {rsp_valid, cmd_ready, hsel}, 32'b100);
      check("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_status", {rsp_error, rsp_timeout}, 32'd0);
      tick;
    end
    cmd_valid = 1'b0;
    garbage   = 1'b0;
    rsp_ready = 1'b1;
    tick;
    check("bp_release", {rsp_valid, cmd_ready}, 32'b01);
    check("bp_txn_count", 32'(txn_count), 32'd6);

    // Reset mid-DATA abandons the transfer without a response.
    hready = 1'b0;
    send(1'b0, 4'd0, 2'd2, 32'h0, 1'b0, mk(32'd0, 1'b0, 1'b0));
    tick;
    check("rst_in_data", 32'(hsel), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_abandon", {hsel, rsp_valid, cmd_ready}, 32'b001);
    check("rst_counters", {txn_count, err_count}, 32'd0);
    hready = 1'b1;
    repeat (3) tick;
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    send(1'b1, 4'd1, 2'd2, 32'hA5A55A5A, 1'b1, mk(32'd0, 1'b0, 1'b0));
    tick;
    tick;
    check("post_rst_rsp", 32'(rsp_valid), 32'd1);
    tick;
    check("post_rst_txn", 32'(txn_count), 32'd1);

    tick;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
